uart8: RTL and testbench

//  Full-duplex 8N1 UART: one transmitter and one receiver sharing clk, each with its own enable.

---
 rtl/uart8.sv | 233 +++++++++++++++++++++++
 tb/tb_uart8.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/uart8.sv
// Full-duplex 8N1 UART: independent transmitter and receiver sharing one clock.
// Optional `UART8_RX_SYNC_EN adds a 2-flop synchronizer on rxIn (+2 clk rx latency).
//
//  state     | meaning
//  ----------+------------------------------------------------------------
//  TX_IDLE   | line high, waiting for txEn & txStart
//  TX_START  | driving start bit (0) for TX_DIV cycles
//  TX_DATA   | shifting 8 data bits LSB first, TX_DIV cycles each
//  TX_STOP   | driving stop bit (1); txDone pulses as it completes
//  RX_IDLE   | armed, waiting for a falling line
//  RX_START  | half-bit qualify of the start bit; line high at tick 8 = glitch
//  RX_DATA   | sampling 8 data bits at mid-bit, every OVERSAMPLE ticks
//  RX_STOP   | sampling stop bit at mid-bit; done or framing error
//  RX_WAIT   | after a framing error, hold off until the line returns high
module uart8 #(
   parameter int CLOCK_RATE = 12000000,
   parameter int BAUD_RATE  = 9600,
   parameter int OVERSAMPLE = 16
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       rxEn,
   input  logic       rxIn,
   output logic       rxBusy,
   output logic       rxDone,
   output logic       rxErr,
   output logic [7:0] rxOut,
   input  logic       txEn,
   input  logic       txStart,
   input  logic [7:0] txIn,
   output logic       txBusy,
   output logic       txDone,
   output logic       txOut
);

   localparam int TX_DIV = CLOCK_RATE / BAUD_RATE;
   localparam int RX_DIV = CLOCK_RATE / (BAUD_RATE * OVERSAMPLE);
   localparam int TXW    = $clog2(TX_DIV + 1);
   localparam int RXW    = $clog2(RX_DIV + 1);
   localparam int TKW    = $clog2(OVERSAMPLE + 1);
   localparam logic [TXW-1:0] TX_RELOAD = TXW'(TX_DIV - 1);
   localparam logic [RXW-1:0] RX_RELOAD = RXW'(RX_DIV - 1);
   localparam logic [TKW-1:0] TICK_BIT  = TKW'(OVERSAMPLE - 1);
   localparam logic [TKW-1:0] TICK_HALF = TKW'(OVERSAMPLE / 2 - 1);

   typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} txState_t;
   typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT} rxState_t;

   // ---------------- transmitter ----------------
   txState_t       txState, txStateNext;
   logic [TXW-1:0] txCnt;
   logic [2:0]     txBit;
   logic [7:0]     txShift;
   logic           txTc, txLoad, txShiftEn, txDoneNext;

   assign txTc = (txCnt == '0);

   always_comb begin
      txStateNext = txState;
      txLoad      = 1'b0;
      txShiftEn   = 1'b0;
      txDoneNext  = 1'b0;
      txOut       = 1'b1;
      txBusy      = 1'b1;
      case (txState)
         TX_IDLE: begin
            txBusy = 1'b0;
            if (txStart) begin
               txStateNext = TX_START;
               txLoad      = 1'b1;
            end
         end
         TX_START: begin
            txOut = 1'b0;
            if (txTc) txStateNext = TX_DATA;
         end
         TX_DATA: begin
            txOut = txShift[0];
            if (txTc) begin
               txShiftEn = 1'b1;
               if (txBit == 3'd0) txStateNext = TX_STOP;
            end
         end
         TX_STOP: begin
            if (txTc) begin
               txStateNext = TX_IDLE;
               txDoneNext  = 1'b1;
            end
         end
         default: txStateNext = TX_IDLE;
      endcase
      // Disable wins over everything, including an in-flight frame.
      if (!txEn) begin
         txStateNext = TX_IDLE;
         txLoad      = 1'b0;
         txShiftEn   = 1'b0;
         txDoneNext  = 1'b0;
         txOut       = 1'b1;
         txBusy      = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         txState <= TX_IDLE;
         txCnt   <= '0;
         txBit   <= '0;
         txShift <= '0;
         txDone  <= 1'b0;
      end else begin
         txState <= txStateNext;
         txDone  <= txDoneNext;
         if (txLoad) begin
            txShift <= txIn;
            txCnt   <= TX_RELOAD;
            txBit   <= 3'd7;
         end else if (txState != TX_IDLE) begin
            txCnt <= txTc ? TX_RELOAD : txCnt - TXW'(1);
            if (txShiftEn) begin
               txShift <= txShift >> 1;
               txBit   <= txBit - 3'd1;
            end
         end
      end
   end

   // ---------------- receiver ----------------
   logic rxS;
`ifdef UART8_RX_SYNC_EN
   logic [1:0] rxSync;
   always_ff @(posedge clk) begin
      if (reset) rxSync <= 2'b11;
      else       rxSync <= {rxSync[0], rxIn};
   end
   assign rxS = rxSync[1];
`else
   assign rxS = rxIn;
`endif

   rxState_t       rxState, rxStateNext;
   logic [RXW-1:0] rxDivCnt;
   logic [TKW-1:0] rxTickCnt;
   logic [2:0]     rxBit;
   logic [7:0]     rxShift;
   logic           rxTick, rxEvent, rxLoad, rxSample, rxDoneNext, rxErrNext;

   assign rxTick  = (rxDivCnt == '0);
   assign rxEvent = rxTick && (rxTickCnt == '0);

   always_comb begin
      rxStateNext = rxState;
      rxLoad      = 1'b0;
      rxSample    = 1'b0;
      rxDoneNext  = 1'b0;
      rxErrNext   = 1'b0;
      rxBusy      = 1'b0;
      case (rxState)
         RX_IDLE: begin
            if (!rxS) begin
               rxStateNext = RX_START;
               rxLoad      = 1'b1;
            end
         end
         RX_START: begin
            rxBusy = 1'b1;
            if (rxEvent) rxStateNext = rxS ? RX_IDLE : RX_DATA;
         end
         RX_DATA: begin
            rxBusy = 1'b1;
            if (rxEvent) begin
               rxSample = 1'b1;
               if (rxBit == 3'd0) rxStateNext = RX_STOP;
            end
         end
         RX_STOP: begin
            rxBusy = 1'b1;
            if (rxEvent) begin
               if (rxS) begin
                  rxStateNext = RX_IDLE;
                  rxDoneNext  = 1'b1;
               end else begin
                  rxStateNext = RX_WAIT;
                  rxErrNext   = 1'b1;
               end
            end
         end
         RX_WAIT: begin
            if (rxS) rxStateNext = RX_IDLE;
         end
         default: rxStateNext = RX_IDLE;
      endcase
      if (!rxEn) begin
         rxStateNext = RX_IDLE;
         rxLoad      = 1'b0;
         rxSample    = 1'b0;
         rxDoneNext  = 1'b0;
         rxErrNext   = 1'b0;
         rxBusy      = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rxState   <= RX_IDLE;
         rxDivCnt  <= '0;
         rxTickCnt <= '0;
         rxBit     <= '0;
         rxShift   <= '0;
         rxOut     <= 8'h00;
         rxDone    <= 1'b0;
         rxErr     <= 1'b0;
      end else begin
         rxState <= rxStateNext;
         rxDone  <= rxDoneNext;
         rxErr   <= rxErrNext;
         if (rxDoneNext) rxOut <= rxShift;
         if (rxLoad) begin
            rxDivCnt  <= RX_RELOAD;
            rxTickCnt <= TICK_HALF;
            rxBit     <= 3'd7;
         end else if (rxBusy) begin
            rxDivCnt <= rxTick ? RX_RELOAD : rxDivCnt - RXW'(1);
            // After the half-bit qualify, each event lands on the next mid-bit.
            if (rxTick) rxTickCnt <= (rxTickCnt == '0) ? TICK_BIT : rxTickCnt - TKW'(1);
            if (rxSample) begin
               rxShift <= {rxS, rxShift[7:1]};
               rxBit   <= rxBit - 3'd1;
            end
         end
      end
   end

endmodule

// File: tb/tb_uart8.sv
// Directed + randomized bench for uart8 at default rates, mostly in txOut->rxIn loopback.
// Expected frames come from a bit-list model {stop, data, start}; received bytes via queues.
module tb_uart8;

   localparam int BIT = 1250;

   logic       clk = 1'b0;
   logic       reset, rxEn, rxIn, rxBusy, rxDone, rxErr;
   logic [7:0] rxOut;
   logic       txEn, txStart, txBusy, txDone, txOut;
   logic [7:0] txIn;
   logic       loopSel, rxDrv;

   int passCnt = 0;
   int checkCnt = 0;
   int txDoneCnt = 0, rxDoneCnt = 0, rxErrCnt = 0;
   logic [7:0] rxQ[$];
   logic [7:0] expQ[$];
   logic [7:0] lastByte;

   always #5 clk = ~clk;

   assign rxIn = loopSel ? txOut : rxDrv;

   uart8 dut (
      .clk(clk), .reset(reset),
      .rxEn(rxEn), .rxIn(rxIn), .rxBusy(rxBusy), .rxDone(rxDone), .rxErr(rxErr), .rxOut(rxOut),
      .txEn(txEn), .txStart(txStart), .txIn(txIn), .txBusy(txBusy), .txDone(txDone), .txOut(txOut)
   );

   always @(posedge clk) begin
      #1;
      if (txDone === 1'b1) txDoneCnt++;
      if (rxErr === 1'b1) rxErrCnt++;
      if (rxDone === 1'b1) begin
         rxDoneCnt++;
         rxQ.push_back(rxOut);
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checkCnt++;
      assert (obs === exp) passCnt++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic checkRxQueue(input string tag);
      check({tag, "_count"}, rxQ.size(), expQ.size());
      while (rxQ.size() > 0 && expQ.size() > 0) begin
         logic [7:0] got, want;
         got  = rxQ.pop_front();
         want = expQ.pop_front();
         check({tag, "_byte"}, got, want);
         lastByte = want;
      end
      rxQ.delete();
      expQ.delete();
   endtask

   // Follows one tx frame: finds the start edge, then samples txOut at each mid-bit.
   task automatic txFrame(input logic [7:0] b, input int dropAt, input logic [7:0] nextIn,
                          input int abortRxAt);
      logic [9:0] fr;
      int n;
      fr = {1'b1, b, 1'b0};
      n = 0;
      while (txOut !== 1'b0 && n < 3000) begin
         @(negedge clk);
         n++;
      end
      check("txStartSeen", txOut, 1'b0);
      for (int k = 0; k < 10; k++) begin
         int w;
         w = (k == 0) ? BIT / 2 - 1 : BIT;
         if (abortRxAt >= 0 && k == abortRxAt + 1) w--;
         repeat (w) @(negedge clk);
         check($sformatf("txBit%0d_%02h", k, b), txOut, fr[k]);
         if (k == dropAt) txStart = 1'b0;
         if (k == 5) txIn = 8'($urandom);
         if (k == 9) txIn = nextIn;
         if (k == abortRxAt) begin
            rxEn = 1'b0;
            @(negedge clk);
            check("rxAbortBusy", rxBusy, 1'b0);
         end
      end
   endtask

   initial begin
      int t0, r0, e0, bad;
      logic [7:0] rb;
      logic [9:0] fr;

      reset = 1'b1; rxEn = 1'b0; txEn = 1'b0; txStart = 1'b0; txIn = 8'h00;
      rxDrv = 1'b1; loopSel = 1'b1; lastByte = 8'h00;
      repeat (4) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      check("rst_txOut", txOut, 1'b1);
      check("rst_txBusy", txBusy, 1'b0);
      check("rst_txDone", txDone, 1'b0);
      check("rst_rxBusy", rxBusy, 1'b0);
      check("rst_rxDone", rxDone, 1'b0);
      check("rst_rxErr", rxErr, 1'b0);
      check("rst_rxOut", rxOut, 8'h00);

      // Loopback 0x45, txStart held ~3 bit times
      rxEn = 1'b1; txEn = 1'b1;
      t0 = txDoneCnt; e0 = rxErrCnt;
      txIn = 8'h45; txStart = 1'b1; expQ.push_back(8'h45);
      txFrame(8'h45, 2, 8'($urandom), -1);
      repeat (700) @(negedge clk);
      check("lb45_txDone", txDoneCnt - t0, 1);
      check("lb45_rxErr", rxErrCnt - e0, 0);
      checkRxQueue("lb45");
      check("lb45_rxOut", rxOut, lastByte);
      check("lb45_txBusy", txBusy, 1'b0);

      // Back-to-back 0x00 then 0xFF
      t0 = txDoneCnt; e0 = rxErrCnt;
      txIn = 8'h00; txStart = 1'b1;
      expQ.push_back(8'h00); expQ.push_back(8'hFF);
      txFrame(8'h00, -1, 8'hFF, -1);
      txFrame(8'hFF, 8, 8'($urandom), -1);
      repeat (700) @(negedge clk);
      check("b2b_txDone", txDoneCnt - t0, 2);
      check("b2b_rxErr", rxErrCnt - e0, 0);
      checkRxQueue("b2b");

      // Transmitter disabled: start request ignored
      t0 = txDoneCnt; bad = 0;
      txEn = 1'b0; txStart = 1'b1;
      for (int i = 0; i < 1500; i++) begin
         @(negedge clk);
         if (txOut !== 1'b1 || txBusy !== 1'b0) bad++;
      end
      txStart = 1'b0; txEn = 1'b1;
      @(negedge clk);
      check("txEnOff_idle", bad, 0);
      check("txEnOff_txDone", txDoneCnt - t0, 0);

      // Random byte, receiver disabled mid-frame
      t0 = txDoneCnt; r0 = rxDoneCnt; e0 = rxErrCnt;
      rb = 8'($urandom);
      txIn = rb; txStart = 1'b1;
      txFrame(rb, 2, 8'($urandom), 4);
      repeat (700) @(negedge clk);
      check("rxAbort_txDone", txDoneCnt - t0, 1);
      check("rxAbort_rxDone", rxDoneCnt - r0, 0);
      check("rxAbort_rxErr", rxErrCnt - e0, 0);
      check("rxAbort_rxOut", rxOut, lastByte);
      rxEn = 1'b1;

      // Framing error: 0xA5 with stop bit 0, line then held low
      loopSel = 1'b0; rxDrv = 1'b1;
      repeat (10) @(negedge clk);
      r0 = rxDoneCnt; e0 = rxErrCnt;
      fr = {1'b0, 8'hA5, 1'b0};
      for (int k = 0; k < 10; k++) begin
         rxDrv = fr[k];
         repeat (BIT) @(negedge clk);
      end
      repeat (1000) @(negedge clk);
      check("ferr_heldLowBusy", rxBusy, 1'b0);
      rxDrv = 1'b1;
      repeat (100) @(negedge clk);
      check("ferr_rxErr", rxErrCnt - e0, 1);
      check("ferr_rxDone", rxDoneCnt - r0, 0);
      check("ferr_rxOut", rxOut, lastByte);

      // 300-cycle glitch is rejected
      r0 = rxDoneCnt; e0 = rxErrCnt;
      rxDrv = 1'b0;
      repeat (100) @(negedge clk);
      check("glitch_busyHigh", rxBusy, 1'b1);
      repeat (200) @(negedge clk);
      rxDrv = 1'b1;
      repeat (700) @(negedge clk);
      check("glitch_busyLow", rxBusy, 1'b0);
      check("glitch_rxDone", rxDoneCnt - r0, 0);
      check("glitch_rxErr", rxErrCnt - e0, 0);

      // Reset in the middle of a tx frame
      loopSel = 1'b1;
      t0 = txDoneCnt; r0 = rxDoneCnt; e0 = rxErrCnt;
      txIn = 8'($urandom); txStart = 1'b1;
      repeat (3000) @(negedge clk);
      check("rstMid_busyBefore", txBusy, 1'b1);
      txStart = 1'b0; reset = 1'b1;
      @(negedge clk);
      check("rstMid_txOut", txOut, 1'b1);
      check("rstMid_txBusy", txBusy, 1'b0);
      check("rstMid_rxBusy", rxBusy, 1'b0);
      reset = 1'b0; lastByte = 8'h00;
      repeat (1000) @(negedge clk);
      check("rstMid_txDone", txDoneCnt - t0, 0);
      check("rstMid_rxDone", rxDoneCnt - r0, 0);
      check("rstMid_rxErr", rxErrCnt - e0, 0);
      check("rstMid_rxOut", rxOut, lastByte);
      check("rstMid_txOutIdle", txOut, 1'b1);

      $display("%0d/%0d checks passed", passCnt, checkCnt);
      $finish;
   end

endmodule
